// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared width and duty constants for the motor-enable PWM channels.
package pwm_gen_pkg;
   localparam int PWM_WIDTH = 14;
   localparam logic [PWM_WIDTH-1:0] DUTY_OFF = '0;
   localparam logic [PWM_WIDTH-1:0] DUTY_25 = 14'h1000;
   localparam logic [PWM_WIDTH-1:0] DUTY_50 = 14'h2000;
endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: duty request in, enable waveform and period strobe out.
interface pwm_gen_if
   import pwm_gen_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
);
   logic [WIDTH-1:0] duty;
   logic drive;
   logic last;
   modport master(output duty, input drive, input last);
   modport slave(input duty, output drive, output last);
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: fixed 2^WIDTH-clock PWM; duty is latched only as the counter wraps.
module pwm_gen
   import pwm_gen_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input logic clk,
   input logic rst_n,
   pwm_gen_if.slave pwm
);
   logic [WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d;
   logic wrap;
   always_comb begin
      wrap = &cnt_q;
      cnt_d = cnt_q + 1'b1;
      duty_d = wrap ? pwm.duty : duty_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         duty_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         duty_q <= duty_d;
      end
   end
   // Outputs decode registers only, so reset drops drive without waiting for a clock.
   assign pwm.drive = cnt_q < duty_q;
   assign pwm.last = wrap;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: two channels; per-period expected high counts are queued as duty is driven.
`timescale 1ns / 1ps
module tb_pwm_gen;
   import pwm_gen_pkg::*;
   localparam int PMAX = 16383;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mon_en = 1'b0;
   int checks = 0;
   int errors = 0;
   int t = 0;
   int qa[$];
   int qb[$];
   int pos = 0, ca = 0, cb = 0, hia = 0, hib = 0, bada = 0, badb = 0, lbad = 0;
   pwm_gen_if #(.WIDTH(PWM_WIDTH)) a_if ();
   pwm_gen_if #(.WIDTH(PWM_WIDTH)) b_if ();
   pwm_gen #(.WIDTH(PWM_WIDTH)) u_a (.clk(clk), .rst_n(rst_n), .pwm(a_if));
   pwm_gen #(.WIDTH(PWM_WIDTH)) u_b (.clk(clk), .rst_n(rst_n), .pwm(b_if));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic go_to(input int p, input int q);
      while (t < p * (PMAX + 1) + q) begin
         @(negedge clk);
         t++;
      end
   endtask
   task automatic release_rst();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      t = 0;
   endtask
   // Bench-owned period position; drive and last are checked against it every cycle.
   initial forever begin
      @(negedge clk);
      if (!mon_en) begin
         pos = 0; hia = 0; hib = 0; bada = 0; badb = 0; lbad = 0;
      end else begin
         if (pos == 0) begin
            if (qa.size() == 0) chk("a_sb_empty", 0, 1);
            ca = (qa.size() != 0) ? qa.pop_front() : 0;
            if (qb.size() == 0) chk("b_sb_empty", 0, 1);
            cb = (qb.size() != 0) ? qb.pop_front() : 0;
         end
         bada += int'(a_if.drive !== (pos < ca));
         badb += int'(b_if.drive !== (pos < cb));
         hia += int'(a_if.drive === 1'b1);
         hib += int'(b_if.drive === 1'b1);
         lbad += int'(a_if.last !== (pos == PMAX)) + int'(b_if.last !== (pos == PMAX));
         if (pos == PMAX) begin
            chk("a_high", hia, ca);
            chk("b_high", hib, cb);
            chk("a_shape", bada, 0);
            chk("b_shape", badb, 0);
            chk("last_strobe", lbad, 0);
            pos = 0; hia = 0; hib = 0; bada = 0; badb = 0; lbad = 0;
         end else pos++;
      end
   end
   initial begin
      a_if.duty = DUTY_OFF;
      b_if.duty = DUTY_OFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_drive_a", a_if.drive, 0);
      chk("rst_drive_b", b_if.drive, 0);
      chk("rst_last_a", a_if.last, 0);
      chk("rst_last_b", b_if.last, 0);
      qa.push_back(0);
      qb.push_back(0);
      release_rst();
      go_to(0, 50);
      a_if.duty = DUTY_50; qa.push_back(8192);
      b_if.duty = DUTY_25; qb.push_back(4096);
      go_to(1, 100);
      b_if.duty = DUTY_50; qb.push_back(8192);
      go_to(1, PMAX);
      a_if.duty = 14'h3FFF; qa.push_back(16383);
      go_to(2, 0);
      b_if.duty = 14'h1400; qb.push_back(5120);
      go_to(2, 200);
      a_if.duty = DUTY_OFF; qa.push_back(0);
      go_to(3, 300);
      a_if.duty = DUTY_50; qa.push_back(8192);
      b_if.duty = DUTY_25; qb.push_back(4096);
      go_to(4, 5000);
      chk("pre_rst_drive", a_if.drive, 1);
      #1;
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("async_drive_a", a_if.drive, 0);
      chk("async_drive_b", b_if.drive, 0);
      chk("async_cnt", u_a.cnt_q, 0);
      chk("async_duty_q", u_a.duty_q, 0);
      qa.delete();
      qb.delete();
      qa.push_back(0);
      qb.push_back(0);
      repeat (3) @(posedge clk);
      release_rst();
      go_to(0, 37);
      chk("restart_cnt", u_a.cnt_q, 37);
      go_to(0, 400);
      #1;
      chk("post_rst_shape", bada + badb + lbad, 0);
      chk("post_rst_high", hia + hib, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
